// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin pick: first valid source strictly after the last winner.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     i_vld,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;
  logic           w_found;

  // Mask off positions at or below the last winner in a doubled request vector, then take the
  // lowest surviving bit; the wrap-around comes for free from the upper copy.
  always_comb begin
    w_dbl    = {i_vld, i_vld};
    w_masked = '0;
    w_found  = 1'b0;
    o_idx    = '0;
    for (int i = 0; i < 2*N; i++) begin
      w_masked[i] = w_dbl[i] && (i > int'(i_ptr));
    end
    for (int i = 0; i < 2*N; i++) begin
      if (!w_found && w_masked[i]) begin
        w_found = 1'b1;
        o_idx   = IDX_W'(i % N);
      end
    end
  end

  assign o_any = |i_vld;

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Packet-locked round-robin sharing of one FIFO write port; words tagged {src_id,last,data}.
module fifo_wr_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 256,
  localparam int ID_W     = clog2_min1(N_REQ),
  localparam int OUT_W    = WIDTH + ID_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic                   fifo_full,
  input  logic                   fifo_afull,
  output logic                   fifo_wren,
  output logic [OUT_W-1:0]       fifo_wdata,
  output logic                   grant_vld,
  output logic [ID_W-1:0]        grant_id,
  output logic                   err_long
);

  localparam int              CNT_W    = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_REQ - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_wren;
  logic [OUT_W-1:0] r_wdata;
  logic             r_err_long;

  logic             w_any;
  logic [ID_W-1:0]  w_pick;
  logic             w_space;
  logic             w_accept;
  logic             w_sel_last;
  logic             w_force;
  logic             w_end;
  logic [WIDTH-1:0] w_sel_data;

  fifo_arb_rr_pick #(.N(N_REQ)) u_pick (
    .i_vld (req_vld),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  assign w_space    = ~fifo_afull & ~fifo_full;
  assign w_sel_data = req_data[int'(r_grant_id)*WIDTH +: WIDTH];

  // Next-state decode plus the owner's ready, accept strobe and packet-end detection.
  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = '0;
    w_accept    = 1'b0;
    w_sel_last  = req_last[r_grant_id];
    w_force     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) w_state_nxt = ARB_BURST;
      end
      ARB_BURST: begin
        req_rdy[r_grant_id] = w_space;
        w_accept = req_vld[r_grant_id] & w_space;
        w_force  = w_accept & ~w_sel_last & (r_beat_cnt == CNT_LAST);
        w_end    = w_accept & (w_sel_last | w_force);
        if (w_end) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM state register; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Capture the winner and advance the round-robin pointer at each arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= PTR_INIT;
      r_grant_id <= '0;
    end else if (r_state == ARB_IDLE && w_any) begin
      r_rr_ptr   <= w_pick;
      r_grant_id <= w_pick;
    end
  end

  // Beats accepted in the current packet; cleared when the packet ends or is cut.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_beat_cnt <= '0;
    else if (w_end)    r_beat_cnt <= '0;
    else if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  // Registered FIFO write one clock after accept; the word holds between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wren  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wren <= w_accept;
      if (w_accept) r_wdata <= {r_grant_id, w_sel_last | w_force, w_sel_data};
    end
  end

  // Sticky overlong-packet flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_err_long <= 1'b0;
    else if (w_force) r_err_long <= 1'b1;
  end

  assign fifo_wren  = r_wren;
  assign fifo_wdata = r_wdata;
  assign grant_vld  = (r_state == ARB_BURST);
  assign grant_id   = r_grant_id;
  assign err_long   = r_err_long;

endmodule
